// File: rtl/seq_generator_if.sv
// seq_generator_if: pattern/burst control inputs and serial link outputs of
// the seq_generator transmitter, with master (driver) and slave (DUT) views.
interface seq_generator_if #(
  parameter int W = 8
);
  logic [W-1:0] setd;
  logic         start;
  logic [3:0]   rep;
  logic [3:0]   gap;
  logic         ds;
  logic [3:0]   c;
  logic         busy;
  logic         frame_done;
  logic         done;

  // The side that requests bursts and observes the serial stream.
  modport master (
    output setd, start, rep, gap,
    input  ds, c, busy, frame_done, done
  );

  // The transmitter itself.
  modport slave (
    input  setd, start, rep, gap,
    output ds, c, busy, frame_done, done
  );
endinterface

// File: rtl/seq_generator.sv
// seq_generator: serial pattern transmitter for the sqdetector link.
// Shifts a latched W-bit pattern out MSB-first on ds, sending rep+1 frames
// separated by gap idle (fill) cycles. All outputs are registered.
// Optional build macro SEQ_GENERATOR_FILL_INV_EN: the fill value driven while
// idle or in a gap becomes the inverse of the pattern MSB (live setd in IDLE,
// latched pattern in GAP) so idle fill never advances a paired detector.
// W must be a power of two between 2 and 16 so the bit index fits the 4-bit c.
module seq_generator #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          clrn,
  seq_generator_if.slave bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(W - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_r;
  logic [W-1:0]  pat_r;
  logic [3:0]    frames_left_r;
  logic [3:0]    gap_len_r;
  logic [3:0]    gap_cnt_r;
  logic [CW-1:0] c_r;
  logic          ds_r;
  logic          busy_r;
  logic          frame_done_r;
  logic          done_r;

  logic [CW-1:0] c_inc_s;
  logic          fill_idle_s;
  logic          fill_gap_s;

  assign c_inc_s = c_r + CW'(1);

`ifdef SEQ_GENERATOR_FILL_INV_EN
  // Inverted MSB keeps the detector parked in its start state during fill.
  assign fill_idle_s = ~bus.setd[W-1];
  assign fill_gap_s  = ~pat_r[W-1];
`else
  assign fill_idle_s = 1'b0;
  assign fill_gap_s  = 1'b0;
`endif

  // Burst FSM: latches a request in IDLE, shifts frames in SEND, idles in GAP;
  // every output is updated here so nothing reaches a port combinationally.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r       <= IDLE;
      pat_r         <= '0;
      frames_left_r <= 4'd0;
      gap_len_r     <= 4'd0;
      gap_cnt_r     <= 4'd0;
      c_r           <= '0;
      ds_r          <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          frame_done_r <= 1'b0;
          done_r       <= 1'b0;
          c_r          <= '0;
          if (bus.start) begin
            // First bit goes out in the cycle right after the accepted start.
            pat_r         <= bus.setd;
            frames_left_r <= bus.rep;
            gap_len_r     <= bus.gap;
            gap_cnt_r     <= 4'd0;
            ds_r          <= bus.setd[W-1];
            busy_r        <= 1'b1;
            state_r       <= SEND;
          end else begin
            ds_r    <= fill_idle_s;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end

        SEND: begin
          if (c_r == LAST_IDX) begin
            frame_done_r <= 1'b0;
            done_r       <= 1'b0;
            c_r          <= '0;
            if (frames_left_r == 4'd0) begin
              // Last bit of the last frame was on ds this cycle.
              ds_r    <= fill_idle_s;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else if (gap_len_r == 4'd0) begin
              // Back-to-back frames: next MSB follows with no idle bit.
              ds_r          <= pat_r[W-1];
              busy_r        <= 1'b1;
              frames_left_r <= frames_left_r - 4'd1;
              state_r       <= SEND;
            end else begin
              ds_r          <= fill_gap_s;
              busy_r        <= 1'b1;
              gap_cnt_r     <= gap_len_r;
              frames_left_r <= frames_left_r - 4'd1;
              state_r       <= GAP;
            end
          end else begin
            // Pulses are raised one edge early so they coincide with c=W-1.
            c_r          <= c_inc_s;
            ds_r         <= pat_r[LAST_IDX - c_inc_s];
            busy_r       <= 1'b1;
            frame_done_r <= (c_r == PRE_LAST);
            done_r       <= (c_r == PRE_LAST) && (frames_left_r == 4'd0);
            state_r      <= SEND;
          end
        end

        GAP: begin
          frame_done_r <= 1'b0;
          done_r       <= 1'b0;
          busy_r       <= 1'b1;
          c_r          <= '0;
          if (gap_cnt_r == 4'd1) begin
            // Counter loaded with gap, leaving at 1 gives exactly gap fill cycles.
            ds_r      <= pat_r[W-1];
            gap_cnt_r <= 4'd0;
            state_r   <= SEND;
          end else begin
            ds_r      <= fill_gap_s;
            gap_cnt_r <= gap_cnt_r - 4'd1;
            state_r   <= GAP;
          end
        end

        default: begin
          state_r      <= IDLE;
          c_r          <= '0;
          ds_r         <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ds         = ds_r;
  assign bus.c          = 4'(c_r);
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_seq_generator.sv
// tb_seq_generator: directed plus randomized bursts checked cycle by cycle
// against a frame-level reference model (a queue of expected output cycles).
module tb_seq_generator;

  logic clk;
  logic clrn;
  int   n_checks;
  int   n_errors;

  seq_generator_if #(.W(8)) bus ();

  seq_generator #(.W(8)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_GENERATOR_FILL_INV_EN
  localparam bit FILL_INV = 1'b1;
`else
  localparam bit FILL_INV = 1'b0;
`endif

  typedef struct packed {
    logic       ds;
    logic [3:0] c;
    logic       busy;
    logic       fd;
    logic       dn;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  function automatic logic fill_of(input logic msb);
    return FILL_INV ? ~msb : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check("ds", 32'(bus.ds), 32'(e.ds));
    check("c", 32'(bus.c), 32'(e.c));
    check("busy", 32'(bus.busy), 32'(e.busy));
    check("frame_done", 32'(bus.frame_done), 32'(e.fd));
    check("done", 32'(bus.done), 32'(e.dn));
  endtask

  // Expand an accepted burst into its full cycle-by-cycle output sequence.
  task automatic build_burst(input logic [7:0] pat, input int rep, input int gap);
    exp_t e;
    for (int f = 0; f <= rep; f++) begin
      for (int i = 0; i < 8; i++) begin
        e.ds   = pat[7 - i];
        e.c    = 4'(i);
        e.busy = 1'b1;
        e.fd   = (i == 7);
        e.dn   = (i == 7) && (f == rep);
        q.push_back(e);
      end
      if (f < rep) begin
        for (int g = 0; g < gap; g++) begin
          e.ds   = fill_of(pat[7]);
          e.c    = 4'd0;
          e.busy = 1'b1;
          e.fd   = 1'b0;
          e.dn   = 1'b0;
          q.push_back(e);
        end
      end
    end
  endtask

  // One clock: model the edge from the current inputs, then compare.
  task automatic step();
    exp_t e;
    if (!cur.busy && q.size() == 0 && bus.start === 1'b1)
      build_burst(bus.setd, int'(bus.rep), int'(bus.gap));
    if (q.size() > 0) begin
      e = q.pop_front();
    end else begin
      e.ds   = fill_of(bus.setd[7]);
      e.c    = 4'd0;
      e.busy = 1'b0;
      e.fd   = 1'b0;
      e.dn   = 1'b0;
    end
    cur = e;
    @(posedge clk);
    @(negedge clk);
    check_outputs(cur);
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic [3:0] r, input logic [3:0] g);
    bus.setd  = d;
    bus.start = s;
    bus.rep   = r;
    bus.gap   = g;
  endtask

  task automatic run_burst(input logic [7:0] d, input logic [3:0] r, input logic [3:0] g, input int extra);
    drive(d, 1'b1, r, g);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < (int'(r) + 1) * 8 + int'(r) * int'(g) - 1 + extra; k++) step();
  endtask

  exp_t zero_e;

  initial begin
    n_checks = 0;
    n_errors = 0;
    zero_e   = '0;
    clrn     = 1'b0;
    drive(8'h00, 1'b0, 4'd0, 4'd0);
    q.delete();

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    check_outputs(zero_e);
    clrn = 1'b1;
    cur  = zero_e;
    step();

    // Single frame, back to idle.
    run_burst(8'b1011_0010, 4'd0, 4'd0, 3);
    // Three frames with 3-cycle gaps.
    run_burst(8'hA5, 4'd2, 4'd3, 3);
    // Two back-to-back all-ones frames.
    run_burst(8'hFF, 4'd1, 4'd0, 2);

    // Restart attempt mid-burst with a new pattern must be ignored.
    drive(8'h3C, 1'b1, 4'd0, 4'd0);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) step();
    drive(8'h00, 1'b1, 4'd5, 4'd7);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) step();

    // Start in the done cycle is ignored; accepted one cycle later.
    drive(8'h96, 1'b1, 4'd0, 4'd0);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) step();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) step();

    // Asynchronous reset in the middle of a frame.
    drive(8'hC3, 1'b1, 4'd3, 4'd2);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2;
    clrn = 1'b0;
    #1;
    check_outputs(zero_e);
    q.delete();
    cur = zero_e;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs(zero_e);
    end
    clrn = 1'b1;
    for (int k = 0; k < 4; k++) step();

    // Randomized bursts with inputs wandering while busy.
    for (int k = 0; k < 4000; k++) begin
      bus.setd  = 8'($urandom);
      bus.rep   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      bus.gap   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      bus.start = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
